// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and operand forwarding.
// Ports: i_clk/i_rst_n, register addresses per stage, mem req/ack, stall/flush/fwd outputs, error and counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_rs1_addr_D,
  input  logic [4:0]  i_rs2_addr_D,
  input  logic [4:0]  i_rs1_addr_E,
  input  logic [4:0]  i_rs2_addr_E,
  input  logic [4:0]  i_rd_addr_E,
  input  logic        i_rd_wren_E,
  input  logic [1:0]  i_wb_sel_E,
  input  logic [4:0]  i_rd_addr_M,
  input  logic        i_rd_wren_M,
  input  logic [4:0]  i_rd_addr_W,
  input  logic        i_rd_wren_W,
  input  logic        i_mispred_E,
  input  logic        i_mem_req_M,
  input  logic        i_mem_ack,
  output logic        o_stall_F,
  output logic        o_stall_D,
  output logic        o_stall_E,
  output logic        o_stall_M,
  output logic        o_flush_D,
  output logic        o_flush_E,
  output logic        o_flush_W,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b,
  output logic        o_err,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [1:0] WB_LOAD   = 2'd1;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEM   = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  state_t     state;
  state_t     state_nx;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nx;

  logic mem_busy;
  logic mem_hold;
  logic mis_take;
  logic load_use;

  assign mem_busy = i_mem_req_M & ~i_mem_ack;

  // Error state keeps the pipe frozen even after the request drops.
  assign mem_hold = (state == ERROR) | mem_busy;

  // Mispredict only redirects from RUN; the ack cycle of a wait is
  // still spent in MEM_WAIT, so the flush lands one cycle later.
  assign mis_take = ~mem_hold & (state == RUN) & i_mispred_E;

  assign load_use = i_rd_wren_E
                  & (i_wb_sel_E == WB_LOAD)
                  & (i_rd_addr_E != 5'd0)
                  & ((i_rd_addr_E == i_rs1_addr_D)
                   | (i_rd_addr_E == i_rs2_addr_D));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = 8'd0;
    unique case (state)
      RUN: begin
        if (mem_busy) state_nx = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_nx = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERROR;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      ERROR: begin
        state_nx = ERROR;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  always_comb begin
    o_stall_F = 1'b0;
    o_stall_D = 1'b0;
    o_stall_E = 1'b0;
    o_stall_M = 1'b0;
    o_flush_D = 1'b0;
    o_flush_E = 1'b0;
    o_flush_W = 1'b0;
    if (mem_hold) begin
      o_stall_F = 1'b1;
      o_stall_D = 1'b1;
      o_stall_E = 1'b1;
      o_stall_M = 1'b1;
      o_flush_W = 1'b1;
    end else if (mis_take) begin
      o_flush_D = 1'b1;
      o_flush_E = 1'b1;
    end else if (load_use) begin
      o_stall_F = 1'b1;
      o_stall_D = 1'b1;
      o_flush_E = 1'b1;
    end
  end

  always_comb begin
    o_fwd_a = FWD_RF;
    if (i_rd_wren_M && i_rd_addr_M != 5'd0
        && i_rd_addr_M == i_rs1_addr_E) begin
      o_fwd_a = FWD_MEM;
    end else if (i_rd_wren_W && i_rd_addr_W != 5'd0
                 && i_rd_addr_W == i_rs1_addr_E) begin
      o_fwd_a = FWD_WB;
    end
  end

  always_comb begin
    o_fwd_b = FWD_RF;
    if (i_rd_wren_M && i_rd_addr_M != 5'd0
        && i_rd_addr_M == i_rs2_addr_E) begin
      o_fwd_b = FWD_MEM;
    end else if (i_rd_wren_W && i_rd_addr_W != 5'd0
                 && i_rd_addr_W == i_rs2_addr_E) begin
      o_fwd_b = FWD_WB;
    end
  end

  assign o_err = (state == ERROR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= 32'd0;
      o_flush_cnt <= 32'd0;
    end else begin
      if (o_stall_F && o_stall_cnt != 32'hFFFF_FFFF)
        o_stall_cnt <= o_stall_cnt + 32'd1;
      if (mis_take && o_flush_cnt != 32'hFFFF_FFFF)
        o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Ports: drives all hazard inputs, checks stall/flush/fwd/err/counters.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E;
  logic [4:0]  rd_E, rd_M, rd_W;
  logic        wren_E, wren_M, wren_W;
  logic [1:0]  wb_sel_E;
  logic        mispred, mem_req, mem_ack;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_W;
  logic [1:0]  fwd_a, fwd_b;
  logic        err;
  logic [31:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rs1_addr_D(rs1_D),
    .i_rs2_addr_D(rs2_D),
    .i_rs1_addr_E(rs1_E),
    .i_rs2_addr_E(rs2_E),
    .i_rd_addr_E(rd_E),
    .i_rd_wren_E(wren_E),
    .i_wb_sel_E(wb_sel_E),
    .i_rd_addr_M(rd_M),
    .i_rd_wren_M(wren_M),
    .i_rd_addr_W(rd_W),
    .i_rd_wren_W(wren_W),
    .i_mispred_E(mispred),
    .i_mem_req_M(mem_req),
    .i_mem_ack(mem_ack),
    .o_stall_F(stall_F),
    .o_stall_D(stall_D),
    .o_stall_E(stall_E),
    .o_stall_M(stall_M),
    .o_flush_D(flush_D),
    .o_flush_E(flush_E),
    .o_flush_W(flush_W),
    .o_fwd_a(fwd_a),
    .o_fwd_b(fwd_b),
    .o_err(err),
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W}
  function automatic logic [6:0] ctl();
    return {stall_F, stall_D, stall_E, stall_M,
            flush_D, flush_E, flush_W};
  endfunction

  task automatic idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0;
    rd_E = 0; rd_M = 0; rd_W = 0;
    wren_E = 0; wren_M = 0; wren_W = 0;
    wb_sel_E = 0; mispred = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Advance one rising edge, land just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse away from the clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    #3;
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_scnt", stall_cnt, 32'h0);
    chk("rst_fcnt", flush_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use on rs1: one bubble
    rd_E = 5; wren_E = 1; wb_sel_E = 2'd1; rs1_D = 5;
    #1;
    chk("lu_ctl", 32'(ctl()), 32'b1100010);
    tick();
    wren_E = 0; wb_sel_E = 0; rd_E = 0;
    #1;
    chk("lu_after", 32'(ctl()), 32'h0);
    chk("lu_scnt", stall_cnt, 32'd1);
    // Load-use via rs2
    rd_E = 9; wren_E = 1; wb_sel_E = 2'd1; rs1_D = 3; rs2_D = 9;
    #1;
    chk("lu_rs2", 32'(ctl()), 32'b1100010);
    // Load into x0 is never a hazard
    rd_E = 0; rs1_D = 0; rs2_D = 0;
    #1;
    chk("lu_x0", 32'(ctl()), 32'h0);
    // Non-load producer: no stall
    rd_E = 5; rs1_D = 5; wb_sel_E = 2'd0;
    #1;
    chk("lu_alu", 32'(ctl()), 32'h0);
    idle();
    do_reset();

    // Mispredict single cycle
    mispred = 1;
    #1;
    chk("mis_ctl", 32'(ctl()), 32'b0000110);
    tick();
    mispred = 0;
    #1;
    chk("mis_after", 32'(ctl()), 32'h0);
    chk("mis_fcnt", flush_cnt, 32'd1);
    chk("mis_scnt", stall_cnt, 32'd0);
    // Mispredict beats load-use
    mispred = 1;
    rd_E = 5; wren_E = 1; wb_sel_E = 2'd1; rs1_D = 5;
    #1;
    chk("mis_over_lu", 32'(ctl()), 32'b0000110);
    idle();
    do_reset();

    // Memory wait 3 cycles with mispredict held
    mem_req = 1; mispred = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stall%0d", i), 32'(ctl()), 32'b1111001);
      tick();
    end
    mem_ack = 1;
    #1;
    chk("mw_ack", 32'(ctl()), 32'h0);
    tick();
    mem_req = 0; mem_ack = 0;
    #1;
    chk("mw_mis", 32'(ctl()), 32'b0000110);
    tick();
    mispred = 0;
    #1;
    chk("mw_scnt", stall_cnt, 32'd3);
    chk("mw_fcnt", flush_cnt, 32'd1);
    idle();
    do_reset();

    // Timeout to ERROR
    mem_req = 1;
    for (int i = 1; i <= 4; i++) tick();
    chk("to_err4", 32'(err), 32'h0);
    tick();
    chk("to_err5", 32'(err), 32'h1);
    mem_req = 0; mispred = 1;
    #1;
    chk("to_hold", 32'(ctl()), 32'b1111001);
    tick();
    chk("to_sticky", 32'(err), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", 32'(err), 32'h0);
    chk("to_rst_scnt", stall_cnt, 32'h0);
    chk("to_rst_fcnt", flush_cnt, 32'h0);
    mispred = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("to_run", 32'(ctl()), 32'h0);
    tick();
    chk("to_run_err", 32'(err), 32'h0);

    // Reset in MEM_WAIT returns to RUN
    mem_req = 1;
    tick();
    tick();
    mem_req = 0;
    do_reset();
    chk("mw_rst", 32'(ctl()), 32'h0);

    // Forwarding
    rd_M = 7; wren_M = 1; rd_W = 7; wren_W = 1; rs1_E = 7;
    rs2_E = 0;
    #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'b01);
    chk("fwd_b_x0", 32'(fwd_b), 32'b00);
    rd_M = 0; rs2_E = 0; rd_W = 0;
    #1;
    chk("fwd_b_m0", 32'(fwd_b), 32'b00);
    rd_W = 9; rs2_E = 9; rs1_E = 9; wren_M = 0; rd_M = 9;
    #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'b10);
    chk("fwd_a_wb", 32'(fwd_a), 32'b10);
    wren_W = 0;
    #1;
    chk("fwd_none", 32'({fwd_a, fwd_b}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, legal 2..255: max cycles a MEM-stage access may wait for i_mem_ack before error.
REQ-002 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rs1_addr_D, i_rs2_addr_D  in  5 each  source regs of instruction in ID.
- i_rs1_addr_E, i_rs2_addr_E  in  5 each  source regs of instruction in EX.
- i_rd_addr_E  in  5; i_rd_wren_E  in  1; i_wb_sel_E  in  2  EX destination, write enable, write-back select (2'd1 = load data).
- i_rd_addr_M  in  5; i_rd_wren_M  in  1  MEM destination and write enable.
- i_rd_addr_W  in  5; i_rd_wren_W  in  1  WB destination and write enable.
- i_mispred_E  in  1  branch mispredict resolved in EX.
- i_mem_req_M  in  1  load/store access active in MEM.
- i_mem_ack  in  1  data memory completes access this cycle.
- o_stall_F, o_stall_D, o_stall_E, o_stall_M  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM.
- o_flush_D, o_flush_E, o_flush_W  out  1 each  bubble into IF/ID, ID/EX, MEM/WB (clears rd_wren, wb_sel).
- o_fwd_a, o_fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB data.
- o_err  out  1  sticky memory timeout.
- o_stall_cnt  out  32  cycles with o_stall_F=1.
- o_flush_cnt  out  32  mispredict flushes taken.

Function
REQ-003 SHALL implement FSM states RUN, MEM_WAIT, ERROR.
REQ-004 SHALL define mem_busy = i_mem_req_M & ~i_mem_ack.
REQ-005 RUN -> MEM_WAIT when mem_busy; MEM_WAIT -> RUN in cycle i_mem_ack=1; MEM_WAIT -> ERROR when wait counter = MEM_TIMEOUT-1 and i_mem_ack=0; ERROR exits only via reset.
REQ-006 Wait counter (8 bit) SHALL clear on RUN and increment each MEM_WAIT cycle.
REQ-007 mem_busy in RUN/MEM_WAIT, or state ERROR: o_stall_F/D/E/M=1, o_flush_W=1, o_flush_D=o_flush_E=0, priority highest.
REQ-008 Else, i_mispred_E=1 (RUN only): o_flush_D=o_flush_E=1 for that cycle only, no stalls; o_flush_cnt +1.
REQ-009 Else, load-use (i_rd_wren_E & i_wb_sel_E==2'd1 & i_rd_addr_E!=0 & i_rd_addr_E matches i_rs1_addr_D or i_rs2_addr_D): o_stall_F=o_stall_D=1, o_flush_E=1, exactly one bubble.
REQ-010 Else all stall/flush outputs 0.
REQ-011 Stall/flush outputs SHALL be combinational from state and current inputs (same-cycle response).
REQ-012 i_mispred_E during mem_busy SHALL be ignored that cycle; honoured in first non-busy cycle while still asserted.
REQ-013 o_fwd_a: 01 if i_rd_wren_M & i_rd_addr_M!=0 & i_rd_addr_M==i_rs1_addr_E; else 10 if same test on W; else 00. MEM beats WB; x0 never forwarded. o_fwd_b likewise with i_rs2_addr_E.
REQ-014 o_err SHALL be 1 exactly when state=ERROR, registered.
REQ-015 o_stall_cnt, o_flush_cnt SHALL saturate at 32'hFFFF_FFFF, not wrap.

Reset
REQ-016 i_rst_n=0 SHALL immediately, independent of i_clk, force state RUN, wait counter 0, o_err=0, both counters 0.
REQ-017 Reset mid-MEM_WAIT or in ERROR SHALL return to RUN; stalls then follow inputs only.
REQ-018 First rising i_clk after i_rst_n rises SHALL be normal operation.

Verification
REQ-019 Load x5 in EX (wb_sel=1, rd=5), ID rs1=5 -> one cycle o_stall_F=o_stall_D=o_flush_E=1, then all 0; o_stall_cnt=1.
REQ-020 i_mispred_E=1 one cycle, no mem access -> o_flush_D=o_flush_E=1 that cycle, o_flush_cnt=1, no stalls.
REQ-021 i_mem_req_M=1, i_mem_ack after 3 cycles, i_mispred_E=1 throughout -> 3 stall cycles with o_flush_W=1, mispredict flush in ack+1 cycle, o_stall_cnt=3.
REQ-022 MEM_TIMEOUT=4, i_mem_req_M=1, no ack -> o_err=1 after 5th rising edge, stalls held; i_rst_n pulse -> o_err=0, counters 0.
REQ-023 rd_M=rd_W=7 both writing, rs1_E=7 -> o_fwd_a=01; rd_M=0 and rs2_E=0 -> o_fwd_b=00.
